// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: issues fetch addresses, steers on BTB hits,
// applies execute redirects and forwards resolved-branch updates to the BTB.
module fetch_pc_gen #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic        fetch_req,
   output logic [30:0] fetch_addr,
   input  logic        fetch_gnt,
   output logic        btb_rd,
   output logic [30:0] pc_r,
   input  logic        btb_hit,
   input  logic [30:0] target_pc_r,
   output logic        btb_wr,
   output logic        btb_invalid,
   output logic [30:0] pc_w,
   output logic [31:0] target_pc_w,
   input  logic        ex_br_valid,
   input  logic [30:0] ex_br_pc,
   input  logic        ex_br_taken,
   input  logic        ex_br_pred_hit,
   input  logic [30:0] ex_br_target,
   input  logic        ex_redirect,
   input  logic [30:0] ex_redirect_pc,
   output logic        pred_valid,
   output logic [30:0] pred_pc,
   output logic        pred_taken,
   output logic [30:0] pred_target
);

   localparam int unsigned PC_W = 31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      REDIR = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              f2_valid_q, f2_valid_d;
   logic [PC_W-1:0]   f2_pc_q, f2_pc_d;
   logic [PC_W-1:0]   pc_seq;
   logic              issue;
   logic              f2_taken;

   // State, fetch PC and F2 prediction-stage registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= BOOT_ADDR[31:1];
         f2_valid_q <= 1'b0;
         f2_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         f2_valid_q <= f2_valid_d;
         f2_pc_q    <= f2_pc_d;
      end
   end

   // Next-state, next-PC and all combinational outputs
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      f2_valid_d  = 1'b0;
      f2_pc_d     = f2_pc_q;
      pc_seq      = {pc_q[30:1] + 30'd1, 1'b0};

      // BTB is single ported: a resolved-branch write steals the lookup slot
      btb_wr      = ex_br_valid & (ex_br_taken | ex_br_pred_hit);
      btb_invalid = btb_wr & ~ex_br_taken;
      pc_w        = ex_br_pc;
      target_pc_w = {ex_br_target, 1'b0};

      fetch_req   = (state_q == RUN) & ~ex_redirect & ~btb_wr;
      issue       = fetch_req & fetch_gnt;
      btb_rd      = issue;
      fetch_addr  = pc_q;
      pc_r        = pc_q;

      pred_valid  = f2_valid_q & ~ex_redirect;
      f2_taken    = f2_valid_q & btb_hit;
      pred_taken  = pred_valid & btb_hit;
      pred_pc     = f2_pc_q;
      pred_target = target_pc_r;

      if (ex_redirect) begin
         state_d = REDIR;
      end else begin
         unique case (state_q)
            IDLE, RUN, REDIR: state_d = fetch_en ? RUN : IDLE;
            default:          state_d = IDLE;
         endcase
      end

      if (issue) begin
         f2_pc_d = pc_q;
      end

      // A taken prediction squashes the fetch issued alongside it (1-bubble penalty)
      if (ex_redirect) begin
         pc_d       = ex_redirect_pc;
         f2_valid_d = 1'b0;
      end else if (f2_taken) begin
         pc_d       = target_pc_r;
         f2_valid_d = 1'b0;
      end else if (issue) begin
         pc_d       = pc_seq;
         f2_valid_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed cycle-by-cycle vectors for fetch_pc_gen; addresses in the table are byte addresses.
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   logic        reset, fetch_en, fetch_gnt, btb_hit;
   logic [30:0] target_pc_r;
   logic        ex_br_valid, ex_br_taken, ex_br_pred_hit, ex_redirect;
   logic [30:0] ex_br_pc, ex_br_target, ex_redirect_pc;
   logic        fetch_req, btb_rd, btb_wr, btb_invalid, pred_valid, pred_taken;
   logic [30:0] fetch_addr, pc_r, pc_w, pred_pc, pred_target;
   logic [31:0] target_pc_w;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_pc_gen dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .btb_rd(btb_rd), .pc_r(pc_r), .btb_hit(btb_hit), .target_pc_r(target_pc_r),
      .btb_wr(btb_wr), .btb_invalid(btb_invalid), .pc_w(pc_w), .target_pc_w(target_pc_w),
      .ex_br_valid(ex_br_valid), .ex_br_pc(ex_br_pc), .ex_br_taken(ex_br_taken),
      .ex_br_pred_hit(ex_br_pred_hit), .ex_br_target(ex_br_target),
      .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
      .pred_target(pred_target)
   );

   typedef struct {
      bit        chk;
      bit        rst, en, gnt, hit;
      bit [31:0] tgt;
      bit        rdr;
      bit [31:0] rdrpc;
      bit        brv, brt, brh;
      bit [31:0] brpc, brtgt;
      bit        req;
      bit [31:0] addr;
      bit        rd, pv;
      bit [31:0] ppc;
      bit        pt, wr, inv;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      reset          = v.rst;
      fetch_en       = v.en;
      fetch_gnt      = v.gnt;
      btb_hit        = v.hit;
      target_pc_r    = v.tgt[31:1];
      ex_redirect    = v.rdr;
      ex_redirect_pc = v.rdrpc[31:1];
      ex_br_valid    = v.brv;
      ex_br_taken    = v.brt;
      ex_br_pred_hit = v.brh;
      ex_br_pc       = v.brpc[31:1];
      ex_br_target   = v.brtgt[31:1];
   endtask

   task automatic compare(input vec_t v, input string tag);
      check({tag, ".fetch_req"},  32'(fetch_req),  32'(v.req));
      check({tag, ".fetch_addr"}, 32'(fetch_addr), 32'(v.addr[31:1]));
      check({tag, ".pc_r"},       32'(pc_r),       32'(v.addr[31:1]));
      check({tag, ".btb_rd"},     32'(btb_rd),     32'(v.rd));
      check({tag, ".pred_valid"}, 32'(pred_valid), 32'(v.pv));
      check({tag, ".btb_wr"},     32'(btb_wr),     32'(v.wr));
      if (v.pv) begin
         check({tag, ".pred_pc"},    32'(pred_pc),    32'(v.ppc[31:1]));
         check({tag, ".pred_taken"}, 32'(pred_taken), 32'(v.pt));
         if (v.pt) check({tag, ".pred_target"}, 32'(pred_target), 32'(v.tgt[31:1]));
      end
      if (v.wr) begin
         check({tag, ".btb_invalid"}, 32'(btb_invalid), 32'(v.inv));
         check({tag, ".pc_w"},        32'(pc_w),        32'(v.brpc[31:1]));
         check({tag, ".target_pc_w"}, target_pc_w,      v.brtgt);
      end
   endtask

   // Fields: chk rst en gnt hit tgt | rdr rdrpc | brv brt brh brpc brtgt | req addr rd pv ppc pt wr inv
   initial begin
      vec_t v;
      // Reset and sequential fetch
      tbl.push_back(vec_t'{0, 1,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h80,0,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 1,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h80,0,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h80,0,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h80,1,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h84,1,1,32'h80,0,0,0});
      // BTB hit on 0x84 -> 0x200; 0x88 issued but squashed, stale hit then ignored
      tbl.push_back(vec_t'{1, 0,1,1,1,32'h200, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h88,1,1,32'h84,1,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,1,32'h200, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h200,1,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h204,1,1,32'h200,0,0,0});
      // Redirect to 0x1000
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 1,32'h1000, 0,0,0,32'h0,32'h0, 0,32'h208,0,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h1000,0,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h1000,1,0,32'h0,0,0,0});
      // BTB invalidate, BTB taken write, then a non-writing resolve
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 1,0,1,32'h84,32'h200, 0,32'h1004,0,1,32'h1000,0,1,1});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 1,1,0,32'h300,32'h400, 0,32'h1004,0,0,32'h0,0,1,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 1,0,0,32'h310,32'h500, 1,32'h1004,1,0,32'h0,0,0,0});
      // Grant low for 3 cycles
      tbl.push_back(vec_t'{1, 0,1,0,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h1008,0,1,32'h1004,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,0,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h1008,0,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,0,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h1008,0,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h1008,1,0,32'h0,0,0,0});
      // fetch_en drop and re-enable
      tbl.push_back(vec_t'{1, 0,0,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h100C,1,1,32'h1008,0,0,0});
      tbl.push_back(vec_t'{1, 0,0,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h1010,0,1,32'h100C,0,0,0});
      tbl.push_back(vec_t'{1, 0,0,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h1010,0,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h1010,0,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h1010,1,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h1014,1,1,32'h1010,0,0,0});
      // Reset mid-fetch: F2 entry discarded
      tbl.push_back(vec_t'{0, 1,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h0,0,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h80,0,0,32'h0,0,0,0});
      tbl.push_back(vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h80,1,0,32'h0,0,0,0});

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         if (tbl[i].chk) compare(tbl[i], $sformatf("v%0d", i));
      end

      // Redirect and branch write in the same cycle, restart at the top of memory
      v = vec_t'{1, 0,1,1,0,32'h0, 1,32'hFFFF_FFFC, 1,1,0,32'h500,32'h600, 0,32'h84,0,0,32'h0,0,1,0};
      @(negedge clk); drive(v); #1; compare(v, "redir_wr");
      v = vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 0,32'hFFFF_FFFC,0,0,32'h0,0,0,0};
      @(negedge clk); drive(v); #1; compare(v, "redir_hold");
      v.req = 1; v.rd = 1;
      @(negedge clk); drive(v); #1; compare(v, "wrap_issue");
      // Sequential increment wraps 0xFFFF_FFFC -> 0
      v = vec_t'{1, 0,1,1,0,32'h0, 0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h0,1,1,32'hFFFF_FFFC,0,0,0};
      @(negedge clk); drive(v); #1; compare(v, "wrap_zero");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
